// File: rtl/spi_master_cs.sv
// Chip-select and multi-byte transaction controller in front of an SPI master byte engine.
// Optional feature macro: SPI_CS_RX_COUNT_EN adds the o_RX_Count received-byte counter port.
module spi_master_cs #(
   parameter int MAX_BYTES_PER_CS = 2,
   parameter int CS_INACTIVE_CLKS = 1,
   localparam int CNT_W = $clog2(MAX_BYTES_PER_CS + 1)
) (
   input  logic             i_Clk,
   input  logic             i_Rst_L,
   input  logic [CNT_W-1:0] i_TX_Count,
   input  logic [7:0]       i_TX_Byte,
   input  logic             i_TX_DV,
   output logic             o_TX_Ready,
   output logic             o_RX_DV,
   output logic [7:0]       o_RX_Byte,
   output logic [7:0]       o_M_Byte,
   output logic             o_M_DV,
   input  logic             i_M_Ready,
   input  logic             i_M_RX_DV,
   input  logic [7:0]       i_M_RX_Byte,
   output logic             o_SPI_CS_n
`ifdef SPI_CS_RX_COUNT_EN
   ,
   output logic [CNT_W-1:0] o_RX_Count
`endif
);

   localparam int GAP_W = $clog2(CS_INACTIVE_CLKS + 1);

   typedef enum logic [1:0] {IDLE, XFER, CS_GAP} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] count_q, remaining_q, rx_seen_q, rx_seen_d;
   logic [GAP_W-1:0] gap_q;
   logic             cs_n_q, m_dv_q, launch_q, pend_q, rx_dv_q;
   logic [7:0]       m_byte_q, rx_byte_q;
   logic             tx_ready, accept, xfer_done;

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      tx_ready = 1'b0;
      case (state_q)
         IDLE:    tx_ready = i_M_Ready;
         XFER:    tx_ready = i_M_Ready & ~m_dv_q & ~pend_q & (remaining_q != '0);
         default: tx_ready = 1'b0;
      endcase
      tx_ready = tx_ready & i_Rst_L;
   end

   // A zero-length request is dropped in IDLE; later bytes ignore i_TX_Count entirely.
   assign accept    = i_TX_DV & tx_ready & ((state_q != IDLE) | (i_TX_Count != '0));
   assign xfer_done = (state_q == XFER) & (remaining_q == '0) & (rx_seen_q == count_q)
                      & i_M_Ready & ~pend_q;
   assign rx_seen_d = (i_M_RX_DV && (rx_seen_q != count_q)) ? rx_seen_q + CNT_W'(1) : rx_seen_q;

   // NOTE: sequential state uses non-blocking assignments only, so later statements in the
   // block see the old register values and ordering between always_ff blocks cannot matter.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q     <= IDLE;
         count_q     <= '0;
         remaining_q <= '0;
         rx_seen_q   <= '0;
         gap_q       <= '0;
         cs_n_q      <= 1'b1;
         m_dv_q      <= 1'b0;
         launch_q    <= 1'b0;
         pend_q      <= 1'b0;
         m_byte_q    <= '0;
         rx_dv_q     <= 1'b0;
         rx_byte_q   <= '0;
      end else begin
         rx_dv_q   <= i_M_RX_DV;
         rx_byte_q <= i_M_RX_Byte;
         m_dv_q    <= 1'b0;
         launch_q  <= 1'b0;
         // pend covers the cycles between forwarding a byte and the master dropping ready.
         if (!i_M_Ready) pend_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (accept) begin
                  count_q     <= i_TX_Count;
                  remaining_q <= i_TX_Count - CNT_W'(1);
                  rx_seen_q   <= '0;
                  cs_n_q      <= 1'b0;
                  m_byte_q    <= i_TX_Byte;
                  launch_q    <= 1'b1;
                  pend_q      <= 1'b1;
                  state_q     <= XFER;
               end
            end
            XFER: begin
               // First byte's DV trails the CS fall by one cycle to give the slave setup time.
               if (launch_q) m_dv_q <= 1'b1;
               rx_seen_q <= rx_seen_d;
               if (xfer_done) begin
                  cs_n_q  <= 1'b1;
                  gap_q   <= GAP_W'(CS_INACTIVE_CLKS - 1);
                  state_q <= CS_GAP;
               end else if (accept) begin
                  m_byte_q    <= i_TX_Byte;
                  m_dv_q      <= 1'b1;
                  pend_q      <= 1'b1;
                  remaining_q <= remaining_q - CNT_W'(1);
               end
            end
            CS_GAP: begin
               if (gap_q == '0) state_q <= IDLE;
               else             gap_q   <= gap_q - GAP_W'(1);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef SPI_CS_RX_COUNT_EN
   logic [CNT_W-1:0] rx_count_q;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L)                          rx_count_q <= '0;
      else if ((state_q == IDLE) && accept)  rx_count_q <= '0;
      else if (i_M_RX_DV)                    rx_count_q <= rx_count_q + CNT_W'(1);
   end

   assign o_RX_Count = rx_count_q;
`endif

   assign o_TX_Ready = tx_ready;
   assign o_RX_DV    = rx_dv_q;
   assign o_RX_Byte  = rx_byte_q;
   assign o_M_Byte   = m_byte_q;
   assign o_M_DV     = m_dv_q;
   assign o_SPI_CS_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_cs.sv
// Bench for spi_master_cs driving a behavioural MODE-0 SPI master (2 clocks per half bit,
// MISO looped to MOSI); a rule-based monitor plus directed transactions check the controller.
module tb_spi_master_cs;

   localparam int MAXB = 2;
   localparam int GAP  = 3;
   localparam int CW   = $clog2(MAXB + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CW-1:0] tx_count = '0;
   logic [7:0]    tx_byte = '0;
   logic          tx_dv = 1'b0;
   logic          tx_ready, rx_dv, m_dv, cs_n;
   logic [7:0]    rx_byte, m_byte;
   logic          m_ready, m_rx_dv, sclk, mosi;
   logic [7:0]    m_rx_byte;
   wire           miso = mosi;
`ifdef SPI_CS_RX_COUNT_EN
   logic [CW-1:0] rx_count;
`endif

   always #5 clk = ~clk;

   spi_master_cs #(.MAX_BYTES_PER_CS(MAXB), .CS_INACTIVE_CLKS(GAP)) dut (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_Count(tx_count), .i_TX_Byte(tx_byte),
      .i_TX_DV(tx_dv), .o_TX_Ready(tx_ready), .o_RX_DV(rx_dv), .o_RX_Byte(rx_byte),
      .o_M_Byte(m_byte), .o_M_DV(m_dv), .i_M_Ready(m_ready), .i_M_RX_DV(m_rx_dv),
      .i_M_RX_Byte(m_rx_byte), .o_SPI_CS_n(cs_n)
`ifdef SPI_CS_RX_COUNT_EN
      , .o_RX_Count(rx_count)
`endif
   );

   // Behavioural SPI master byte engine: 16 SCLK edges, one every 2 clocks, sample on rise.
   logic       busy, div;
   logic [4:0] edges;
   logic [7:0] tx_sr, rx_sr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ready <= 1'b0; m_rx_dv <= 1'b0; m_rx_byte <= '0; sclk <= 1'b0; mosi <= 1'b0;
         busy <= 1'b0; div <= 1'b0; edges <= '0; tx_sr <= '0; rx_sr <= '0;
      end else begin
         m_rx_dv <= 1'b0;
         if (!busy) begin
            m_ready <= 1'b1;
            if (m_ready && m_dv) begin
               busy <= 1'b1; m_ready <= 1'b0; div <= 1'b0; edges <= 5'd16;
               mosi <= m_byte[7]; tx_sr <= {m_byte[6:0], 1'b0};
            end
         end else begin
            div <= ~div;
            if (div) begin
               sclk  <= ~sclk;
               edges <= edges - 5'd1;
               if (!sclk) rx_sr <= {rx_sr[6:0], miso};
               else begin
                  mosi  <= tx_sr[7];
                  tx_sr <= {tx_sr[6:0], 1'b0};
               end
               if (edges == 5'd1) begin
                  busy <= 1'b0; m_ready <= 1'b1; m_rx_dv <= 1'b1; m_rx_byte <= rx_sr;
               end
            end
         end
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state: bytes the user legitimately handed over, in order.
   logic [7:0] exp_q[$];
   logic [7:0] rx_log[$];
   int         model_count = 0;
   logic       prev_rx_dv = 1'b0, prev_cs_n = 1'b1, prev_m_dv = 1'b0, prev_sclk = 1'b0;
   logic [7:0] prev_rx_byte = '0;
   int         win_fwd = 0, win_rx = 0, win_sclk = 0, high_cnt = 100;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         rx_log.delete();
         prev_rx_dv = 1'b0; prev_rx_byte = '0; prev_cs_n = 1'b1; prev_m_dv = 1'b0;
         high_cnt = 100;
      end else begin
         check("rx_dv_latency", rx_dv, prev_rx_dv);
         if (prev_rx_dv) check("rx_byte_copy", rx_byte, prev_rx_byte);
         if (rx_dv) rx_log.push_back(rx_byte);
         if (prev_cs_n && !cs_n) begin
            win_fwd = 0; win_rx = 0; win_sclk = 0;
         end
         if (!cs_n) begin
            if (rx_dv) win_rx++;
            if (sclk && !prev_sclk) win_sclk++;
         end
         if (m_dv) begin
            check("cs_low_at_mdv", cs_n, 0);
            check("cs_leads_mdv", prev_cs_n, 0);
            check("mdv_one_cycle", prev_m_dv, 0);
            if (exp_q.size() == 0) check("unexpected_mdv", 1, 0);
            else                   check("m_byte_order", m_byte, exp_q.pop_front());
            win_fwd++;
         end
         if (!prev_cs_n && cs_n) begin
            check("bytes_forwarded", win_fwd, model_count);
            check("rx_before_cs_rise", win_rx, model_count);
            high_cnt = 0;
         end
         if (cs_n) begin
            if (high_cnt < 1000) high_cnt++;
            if (high_cnt <= GAP) check("gap_ready_low", tx_ready, 0);
         end
         prev_rx_dv = m_rx_dv; prev_rx_byte = m_rx_byte;
         prev_cs_n = cs_n; prev_m_dv = m_dv;
      end
      prev_sclk = sclk;
   end

   task automatic wait_ready(input string name);
      int t = 0;
      while (!tx_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check(name, tx_ready, 1);
   endtask

   task automatic wait_cs_high(input string name);
      int t = 0;
      while (!cs_n && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check(name, cs_n, 1);
   endtask

   task automatic send(input logic [CW-1:0] cnt, input logic [7:0] b, input bit legal);
      tx_count = cnt;
      tx_byte  = b;
      tx_dv    = 1'b1;
      if (legal) exp_q.push_back(b);
      @(negedge clk);
      tx_dv = 1'b0;
   endtask

   task automatic expect_rx(input string name, input logic [7:0] b);
      check({name, "_present"}, (rx_log.size() > 0) ? 1 : 0, 1);
      if (rx_log.size() > 0) check(name, rx_log.pop_front(), b);
   endtask

   initial begin
      int n, cs_hi, dvs;
      repeat (3) @(negedge clk);
      check("rst_cs_n", cs_n, 1);
      check("rst_m_dv", m_dv, 0);
      check("rst_m_byte", m_byte, 0);
      check("rst_rx_dv", rx_dv, 0);
      check("rst_rx_byte", rx_byte, 0);
      check("rst_ready_gated", tx_ready, 0);
`ifdef SPI_CS_RX_COUNT_EN
      check("rst_rx_count", rx_count, 0);
`endif
      @(posedge clk); #2 rst_n = 1'b1;
      @(negedge clk);

      // Single byte, then measure the CS-high gap before ready returns.
      wait_ready("t1_ready");
      model_count = 1;
      send(1, 8'hA5, 1);
      check("t1_cs_low", cs_n, 0);
      wait_cs_high("t1_cs_rise");
      n = 0;
      while (!tx_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("t1_gap_cycles", n, 3);
      check("t1_cs_high_at_ready", cs_n, 1);
      expect_rx("t1_rx", 8'hA5);

      // Two bytes under one CS window; second byte's count field must be ignored.
      wait_ready("t2_ready");
      model_count = 2;
      send(2, 8'h3C, 1);
      wait_ready("t2_ready2");
      check("t2_cs_still_low", cs_n, 0);
      send(0, 8'hC3, 1);
      wait_cs_high("t2_cs_rise");
      check("t2_sclk_periods", win_sclk, 16);
      expect_rx("t2_rx0", 8'h3C);
      expect_rx("t2_rx1", 8'hC3);
`ifdef SPI_CS_RX_COUNT_EN
      check("t2_rx_count_end", rx_count, 2);
`endif

      // User withholds the second byte for 100 cycles.
      wait_ready("t3_ready");
      model_count = 2;
      send(2, 8'h96, 1);
`ifdef SPI_CS_RX_COUNT_EN
      check("t3_rx_count_cleared", rx_count, 0);
`endif
      wait_ready("t3_ready2");
      cs_hi = 0; dvs = 0;
      repeat (100) begin
         @(negedge clk);
         if (cs_n) cs_hi++;
         if (m_dv) dvs++;
      end
      check("t3_stall_cs_low", cs_hi, 0);
      check("t3_stall_no_mdv", dvs, 0);
      send(2, 8'h69, 1);
      wait_cs_high("t3_cs_rise");
      expect_rx("t3_rx0", 8'h96);
      expect_rx("t3_rx1", 8'h69);

      // Zero-count request in IDLE, then a DV while the controller is busy.
      wait_ready("t4_ready");
      send(0, 8'h77, 0);
      cs_hi = 0; dvs = 0;
      repeat (10) begin
         @(negedge clk);
         if (!cs_n) cs_hi++;
         if (m_dv) dvs++;
      end
      check("t4_zero_count_cs", cs_hi, 0);
      check("t4_zero_count_mdv", dvs, 0);
      model_count = 1;
      send(1, 8'hE7, 1);
      repeat (6) @(negedge clk);
      check("t4_busy_not_ready", tx_ready, 0);
      send(1, 8'hFF, 0);
      wait_cs_high("t4_cs_rise");
      expect_rx("t4_rx", 8'hE7);
      check("t4_no_extra_rx", rx_log.size(), 0);

      // Reset in the middle of a byte releases CS at once; a fresh transfer then works.
      wait_ready("t5_ready");
      model_count = 1;
      send(1, 8'h11, 1);
      repeat (20) @(negedge clk);
      check("t5_cs_low_before", cs_n, 0);
      #2 rst_n = 1'b0;
      #1;
      check("t5_cs_async", cs_n, 1);
      check("t5_m_dv", m_dv, 0);
      check("t5_m_byte", m_byte, 0);
      check("t5_rx_dv", rx_dv, 0);
      check("t5_rx_byte", rx_byte, 0);
      check("t5_ready", tx_ready, 0);
      repeat (2) @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b1;
      wait_ready("t5_ready2");
      model_count = 1;
      send(1, 8'h5A, 1);
      wait_cs_high("t5_cs_rise");
      expect_rx("t5_rx", 8'h5A);
      check("t5_rx_only_one", rx_log.size(), 0);

      repeat (5) @(negedge clk);
      check("exp_queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
